// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO peripheral.
// Register offsets are byte offsets within the 32-byte window.
package gpio_pkg;

    localparam int GPIO_WIN_BYTES = 32;

    localparam logic [4:0] GPIO_OFF_OUT    = 5'h00;
    localparam logic [4:0] GPIO_OFF_DIR    = 5'h04;
    localparam logic [4:0] GPIO_OFF_IN     = 5'h08;
    localparam logic [4:0] GPIO_OFF_SET    = 5'h0C;
    localparam logic [4:0] GPIO_OFF_CLR    = 5'h10;
    localparam logic [4:0] GPIO_OFF_TGL    = 5'h14;
    localparam logic [4:0] GPIO_OFF_IRQ_EN = 5'h18;
    localparam logic [4:0] GPIO_OFF_PEND   = 5'h1C;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchronizer for the GPIO pads.
// Output q is the last stage of an IN_SYNC-deep flop chain.
module gpio_sync #(
    parameter int N       = 8,
    parameter int IN_SYNC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] chain [IN_SYNC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IN_SYNC; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < IN_SYNC; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[IN_SYNC-1];

endmodule

// File: rtl/gpio_periph.sv
// Memory-mapped GPIO block with set/clear/toggle and edge interrupts.
// Interrupt logic is present only when GPIO_IRQ_EN is defined.
module gpio_periph #(
    parameter int                N       = 8,
    parameter int                ADDR_W  = 10,
    parameter logic [ADDR_W-1:0] BASE    = 10'h380,
    parameter int                IN_SYNC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    input  logic [3:0]        width,
    input  logic              write,
    output logic [31:0]       data_out,
    input  logic [N-1:0]      gpio_in,
    output logic [N-1:0]      gpio_out,
    output logic [N-1:0]      gpio_oe,
    output logic              irq
);

    import gpio_pkg::*;

    logic          sel;
    logic          wr_en;
    logic [4:0]    off;
    logic [31:0]   mask32;
    logic [31:0]   be_bits;
    logic [N-1:0]  wmask;
    logic [N-1:0]  wdat;
    logic [N-1:0]  out_q;
    logic [N-1:0]  dir_q;
    logic [N-1:0]  in_s;
    logic [31:0]   rd;
    logic          unused_bits;

    assign sel     = address[ADDR_W-1:5] == BASE[ADDR_W-1:5];
    assign off     = {address[4:2], 2'b00};
    assign wr_en   = write & sel;
    assign mask32  = be_mask(width);
    assign be_bits = data_in & mask32;
    assign wmask   = mask32[N-1:0];
    assign wdat    = be_bits[N-1:0];

    // Lanes above N and the byte-lane address bits carry no state.
    assign unused_bits = ^{be_bits, mask32, address[1:0]};

    gpio_sync #(
        .N       (N),
        .IN_SYNC (IN_SYNC)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (gpio_in),
        .q   (in_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (wr_en) begin
            unique case (off)
                GPIO_OFF_OUT: out_q <= (out_q & ~wmask) | wdat;
                GPIO_OFF_DIR: dir_q <= (dir_q & ~wmask) | wdat;
                GPIO_OFF_SET: out_q <= out_q | wdat;
                GPIO_OFF_CLR: out_q <= out_q & ~wdat;
                GPIO_OFF_TGL: out_q <= out_q ^ wdat;
                default: ;
            endcase
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;

`ifdef GPIO_IRQ_EN
    logic [N-1:0] en_q;
    logic [N-1:0] pend_q;
    logic [N-1:0] in_d;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic         irq_q;

    assign rise = in_s & ~in_d;
    assign clr  = (wr_en && off == GPIO_OFF_PEND) ? wdat : '0;

    // A new edge overrides a simultaneous W1C of the same bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= '0;
            pend_q <= '0;
            in_d   <= '0;
            irq_q  <= 1'b0;
        end else begin
            in_d   <= in_s;
            pend_q <= (pend_q & ~clr) | rise;
            irq_q  <= |(pend_q & en_q);
            if (wr_en && off == GPIO_OFF_IRQ_EN) begin
                en_q <= (en_q & ~wmask) | wdat;
            end
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd = '0;
        unique case (off)
            GPIO_OFF_OUT:    rd[N-1:0] = out_q;
            GPIO_OFF_DIR:    rd[N-1:0] = dir_q;
            GPIO_OFF_IN:     rd[N-1:0] = in_s;
`ifdef GPIO_IRQ_EN
            GPIO_OFF_IRQ_EN: rd[N-1:0] = en_q;
            GPIO_OFF_PEND:   rd[N-1:0] = pend_q;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else begin
            data_out <= sel ? rd : '0;
        end
    end

endmodule

// File: tb/tb_gpio_periph.sv
// Directed self-checking bench for gpio_periph (N=8, BASE=0x380).
// Interrupt expectations follow whether GPIO_IRQ_EN is defined.
module tb_gpio_periph;

`ifdef GPIO_IRQ_EN
    localparam logic [31:0] IRQ = 32'd1;
`else
    localparam logic [31:0] IRQ = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  width = '0;
    logic        write = 1'b0;
    logic [31:0] data_out;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    gpio_periph dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .data_in  (data_in),
        .width    (width),
        .write    (write),
        .data_out (data_out),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        address = a;
        data_in = d;
        width   = be;
        write   = 1'b1;
        tick();
        write   = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        address = a;
        tick();
    endtask

    initial begin
        #1;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_gpio_out", 32'(gpio_out), 32'h0);
        chk("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        rd(10'h380); chk("rd_out_rst", data_out, 32'h0);
        rd(10'h384); chk("rd_dir_rst", data_out, 32'h0);
        rd(10'h39C); chk("rd_pend_rst", data_out, 32'h0);

        wr(10'h380, 32'h0000_00A5, 4'b0001);
        chk("out_a5", 32'(gpio_out), 32'hA5);
        wr(10'h38C, 32'h0000_000A, 4'b0001);
        chk("set_0a", 32'(gpio_out), 32'hAF);
        wr(10'h390, 32'h0000_0001, 4'b0001);
        chk("clr_01", 32'(gpio_out), 32'hAE);
        wr(10'h394, 32'h0000_00FF, 4'b0001);
        chk("tgl_ff", 32'(gpio_out), 32'h51);

        wr(10'h380, 32'h0, 4'b1111);
        chk("out_zero", 32'(gpio_out), 32'h0);
        wr(10'h380, 32'hFFFF_FFFF, 4'b0010);
        chk("out_be_hi", 32'(gpio_out), 32'h0);
        rd(10'h380); chk("rd_out_be_hi", data_out, 32'h0);

        wr(10'h384, 32'h0000_003C, 4'b0001);
        chk("dir_oe", 32'(gpio_oe), 32'h3C);
        rd(10'h387); chk("rd_dir_lowbits", data_out, 32'h3C);
        rd(10'h38C); chk("rd_set_wo", data_out, 32'h0);

        wr(10'h000, 32'hFF, 4'b1111);
        chk("unsel_wr", 32'(gpio_out), 32'h0);
        rd(10'h004); chk("unsel_rd", data_out, 32'h0);

        wr(10'h388, 32'hFF, 4'b1111);
        gpio_in = 8'h96;
        address = 10'h388;
        tick();
        tick();
        chk("in_latency", data_out, 32'h0);
        tick();
        chk("in_value", data_out, 32'h96);

        gpio_in = 8'h00;
        tick(); tick(); tick();
        wr(10'h39C, 32'hFF, 4'b0001);
        wr(10'h398, 32'h01, 4'b0001);
        rd(10'h398); chk("rd_irq_en", data_out, IRQ);

        gpio_in = 8'h01;
        tick();
        tick();
        chk("irq_e2", 32'(irq), 32'h0);
        tick();
        chk("irq_e3", 32'(irq), 32'h0);
        address = 10'h39C;
        tick();
        chk("irq_e4", 32'(irq), IRQ);
        chk("pend_e4", data_out, IRQ);
        wr(10'h39C, 32'h01, 4'b0001);
        chk("irq_w1c_reg", 32'(irq), IRQ);
        tick();
        chk("irq_w1c", 32'(irq), 32'h0);
        chk("pend_w1c", data_out, 32'h0);

        gpio_in = 8'h00;
        tick(); tick(); tick();
        gpio_in = 8'h01;
        tick();
        tick();
        wr(10'h39C, 32'h01, 4'b0001);
        tick();
        chk("set_wins_pend", data_out, IRQ);
        chk("set_wins_irq", 32'(irq), IRQ);

        wr(10'h380, 32'h5A, 4'b0001);
        chk("out_5a", 32'(gpio_out), 32'h5A);
        address = 10'h380;
        data_in = 32'hFF;
        width   = 4'b1111;
        write   = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_out", 32'(gpio_out), 32'h0);
        chk("mid_rst_oe", 32'(gpio_oe), 32'h0);
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        tick();
        write = 1'b0;
        tick();
        rst = 1'b0;
        chk("post_rst_out", 32'(gpio_out), 32'h0);

        wr(10'h398, 32'h01, 4'b0001);
        tick();
        tick();
        chk("held_hi_e3", 32'(irq), 32'h0);
        tick();
        chk("held_hi_e4", 32'(irq), IRQ);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
